turbo_st2bus: RTL

Downstream neighbour of the turbo decoder wrapper. It accepts the decoder's hard-decision output stream (8-bit beats framed by sop/eop, valid/ready handshake) in the clk_st domain. It packs the beats into 512-bit bus words tagged with a packet id, beat count and last/abort flags. A 2-entry output FIFO feeds the memory write-back path and applies backpressure to the decoder.

---
 rtl/turbo_st2bus_pkg.sv | 37 +++
 rtl/turbo_st2bus_fifo.sv | 48 ++++
 rtl/turbo_st2bus.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/turbo_st2bus_pkg.sv
// Shared widths and the packed bus-word record for the decoder-stream to bus-word packer.
package turbo_st2bus_pkg;
    localparam int ST_W           = 8;
    localparam int BUS_W          = 512;
    localparam int NUM_ST_PER_BUS = BUS_W / ST_W;
    localparam int PKT_ID_W       = 16;
    localparam int FIFO_DEPTH     = 2;
    localparam int LANE_W         = $clog2(NUM_ST_PER_BUS);
    localparam int NBEATS_W       = LANE_W + 1;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic [BUS_W-1:0]    data;
        logic [NBEATS_W-1:0] nbeats;
        logic                last;
        logic                abort;
        logic [PKT_ID_W-1:0] pkt_id;
    } word_t;

    function automatic word_t mk_word(input logic [BUS_W-1:0]    data,
                                      input logic [NBEATS_W-1:0] nbeats,
                                      input logic                last,
                                      input logic                abort,
                                      input logic [PKT_ID_W-1:0] pkt_id);
        word_t w;
        w.data   = data;
        w.nbeats = nbeats;
        w.last   = last;
        w.abort  = abort;
        w.pkt_id = pkt_id;
        return w;
    endfunction
endpackage

// File: rtl/turbo_st2bus_fifo.sv
// Two-entry synchronous FIFO of packed bus words; push is ignored when full, pop when empty.
module turbo_st2bus_fifo
    import turbo_st2bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  word_t      i_word,
    input  logic       i_pop,
    output word_t      o_word,
    output logic       o_full,
    output logic       o_empty,
    output logic [1:0] o_count
);
    word_t      r_mem [FIFO_DEPTH];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_do_push;
    logic       w_do_pop;

    assign o_full    = (r_count == 2'(FIFO_DEPTH));
    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_word    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/turbo_st2bus.sv
// Packs 8-bit decoder beats into 512-bit tagged bus words.
// state   | meaning: S_IDLE | no packet open, waiting for sop;  S_COLLECT | filling lanes of an open packet
module turbo_st2bus
    import turbo_st2bus_pkg::*;
(
    input  logic                clk_st,
    input  logic                rst,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic                st_sop,
    input  logic                st_eop,
    input  logic [ST_W-1:0]     st_data,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [BUS_W-1:0]    bus_data,
    output logic [6:0]          bus_nbeats,
    output logic                bus_last,
    output logic                bus_abort,
    output logic [PKT_ID_W-1:0] bus_pkt_id,
    output logic                err_sop,
    output logic                err_nosop
);
    state_t              r_state, w_state_nxt;
    logic [LANE_W-1:0]   r_lane, w_lane_nxt;
    logic [BUS_W-1:0]    r_asm, w_asm_nxt;
    logic [PKT_ID_W-1:0] r_pkt_id, w_pkt_id_nxt;
    logic                r_pend, w_pend_nxt;
    word_t               r_pend_word, w_pend_word_nxt;
    logic                r_err_sop, w_err_sop;
    logic                r_err_nosop, w_err_nosop;
    logic                w_push;
    word_t               w_push_word;
    word_t               w_head;
    logic                w_fifo_full, w_fifo_empty;
    logic [1:0]          w_fifo_count;
    logic                w_accept;
    logic [BUS_W-1:0]    w_beat_lane0;
    logic [BUS_W-1:0]    w_asm_beat;

    // A sop+eop beat arriving mid-packet yields two words; the second waits in r_pend.
    assign st_ready     = ~rst & ~w_fifo_full & ~r_pend;
    assign w_accept     = st_valid & st_ready;
    assign w_beat_lane0 = BUS_W'(st_data);
    assign w_asm_beat   = r_asm | (w_beat_lane0 << (r_lane * ST_W));

    always_comb begin
        w_state_nxt     = r_state;
        w_lane_nxt      = r_lane;
        w_asm_nxt       = r_asm;
        w_pkt_id_nxt    = r_pkt_id;
        w_pend_nxt      = r_pend;
        w_pend_word_nxt = r_pend_word;
        w_push          = 1'b0;
        w_push_word     = '0;
        w_err_sop       = 1'b0;
        w_err_nosop     = 1'b0;
        if (r_pend) begin
            w_push      = 1'b1;
            w_push_word = r_pend_word;
            if (w_fifo_count != 2'(FIFO_DEPTH)) w_pend_nxt = 1'b0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (!st_sop) begin
                        w_err_nosop = 1'b1;
                    end else if (st_eop) begin
                        w_push       = 1'b1;
                        w_push_word  = mk_word(w_beat_lane0, NBEATS_W'(1), 1'b1, 1'b0, r_pkt_id);
                        w_pkt_id_nxt = r_pkt_id + PKT_ID_W'(1);
                    end else begin
                        w_asm_nxt   = w_beat_lane0;
                        w_lane_nxt  = LANE_W'(1);
                        w_state_nxt = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (st_sop) begin
                        w_push      = 1'b1;
                        w_push_word = mk_word(r_asm, {1'b0, r_lane}, 1'b1, 1'b1, r_pkt_id);
                        w_err_sop   = 1'b1;
                        if (st_eop) begin
                            w_pend_nxt      = 1'b1;
                            w_pend_word_nxt = mk_word(w_beat_lane0, NBEATS_W'(1), 1'b1, 1'b0,
                                                      r_pkt_id + PKT_ID_W'(1));
                            w_pkt_id_nxt    = r_pkt_id + PKT_ID_W'(2);
                            w_asm_nxt       = '0;
                            w_lane_nxt      = '0;
                            w_state_nxt     = S_IDLE;
                        end else begin
                            w_pkt_id_nxt = r_pkt_id + PKT_ID_W'(1);
                            w_asm_nxt    = w_beat_lane0;
                            w_lane_nxt   = LANE_W'(1);
                        end
                    end else if (r_lane == LANE_W'(NUM_ST_PER_BUS - 1) || st_eop) begin
                        w_push      = 1'b1;
                        w_push_word = mk_word(w_asm_beat, {1'b0, r_lane} + NBEATS_W'(1),
                                              st_eop, 1'b0, r_pkt_id);
                        w_asm_nxt   = '0;
                        w_lane_nxt  = '0;
                        if (st_eop) begin
                            w_pkt_id_nxt = r_pkt_id + PKT_ID_W'(1);
                            w_state_nxt  = S_IDLE;
                        end
                    end else begin
                        w_asm_nxt  = w_asm_beat;
                        w_lane_nxt = r_lane + LANE_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_st) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lane      <= '0;
            r_asm       <= '0;
            r_pkt_id    <= '0;
            r_pend      <= 1'b0;
            r_pend_word <= '0;
            r_err_sop   <= 1'b0;
            r_err_nosop <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lane      <= w_lane_nxt;
            r_asm       <= w_asm_nxt;
            r_pkt_id    <= w_pkt_id_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_word <= w_pend_word_nxt;
            r_err_sop   <= w_err_sop;
            r_err_nosop <= w_err_nosop;
        end
    end

    turbo_st2bus_fifo u_fifo (
        .clk     (clk_st),
        .rst     (rst),
        .i_push  (w_push),
        .i_word  (w_push_word),
        .i_pop   (bus_ready),
        .o_word  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign bus_valid  = ~w_fifo_empty;
    assign bus_data   = w_head.data;
    assign bus_nbeats = w_head.nbeats;
    assign bus_last   = w_head.last;
    assign bus_abort  = w_head.abort;
    assign bus_pkt_id = w_head.pkt_id;
    assign err_sop    = r_err_sop;
    assign err_nosop  = r_err_nosop;
endmodule
